// File: rtl/jtag_strap_mux_pkg.sv
// Shared types and constants for the strap-selected JTAG overlay mux.
package jtag_strap_mux_pkg;

  typedef enum logic {
    SAMPLE = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int unsigned TapNone = 0;

  // Levels presented to a TAP that is not currently routed to the pins.
  localparam logic IdleTck   = 1'b0;
  localparam logic IdleTms   = 1'b1;
  localparam logic IdleTdi   = 1'b0;
  localparam logic IdleTrstN = 1'b0;
  localparam logic IdleSrstN = 1'b1;

endpackage

// File: rtl/jtag_strap_mux_debounce.sv
// Strap synchroniser and stability counter; flags when the synchronised
// strap has held one value for DebounceCycles consecutive samples.
module jtag_strap_debounce #(
  parameter int unsigned Width          = 2,
  parameter int unsigned DebounceCycles = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [Width-1:0] i_strap,
  output logic [Width-1:0] o_value,
  output logic             o_stable
);

  localparam int unsigned       CntW    = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0]   CntLast = CntW'(DebounceCycles - 1);

  logic [Width-1:0] r_sync1;
  logic [Width-1:0] r_sync2;
  logic [CntW-1:0]  r_cnt;
  logic             w_equal;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_strap;
      r_sync2 <= r_sync1;
    end
  end

  // The first stage is the next synchronised sample, so comparing the two
  // stages tells whether the strap will still hold its value next cycle.
  assign w_equal = (r_sync1 == r_sync2);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_en || !w_equal) begin
      r_cnt <= '0;
    end else if (r_cnt != CntLast) begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  assign o_value  = r_sync2;
  assign o_stable = i_en && w_equal && (r_cnt == CntLast);

endmodule

// File: rtl/jtag_strap_mux.sv
// Strap-selected JTAG overlay between padring and core pin mux.
// Optional synchronised system reset per TAP: define JTAG_STRAP_MUX_SRST_EN.
//
// state  | meaning
// SAMPLE | strap being debounced; no TAP routed, locked_o low
// LOCKED | selection latched; TAP routed when tap_sel_o is non-zero
module jtag_strap_mux
  import jtag_strap_mux_pkg::*;
#(
  parameter int unsigned       NumIOs         = 47,
  parameter int unsigned       NumTaps        = 2,
  parameter int unsigned       StrapWidth     = 2,
  parameter int unsigned       StrapIdx       = 16,
  parameter int unsigned       TckIdx         = 43,
  parameter int unsigned       TmsIdx         = 44,
  parameter int unsigned       TdiIdx         = 45,
  parameter int unsigned       TdoIdx         = 46,
  parameter int unsigned       TrstIdx        = 18,
  parameter int unsigned       SrstIdx        = 19,
  parameter logic [NumIOs-1:0] TieOffValues   = '0,
  parameter int unsigned       DebounceCycles = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  debug_en_i,
  input  logic                  resample_i,
  output logic [StrapWidth-1:0] tap_sel_o,
  output logic                  locked_o,
  output logic                  strap_err_o,
  output logic [NumTaps-1:0]    jtag_tck_o,
  output logic [NumTaps-1:0]    jtag_tms_o,
  output logic [NumTaps-1:0]    jtag_trst_no,
  output logic [NumTaps-1:0]    jtag_srst_no,
  output logic [NumTaps-1:0]    jtag_tdi_o,
  input  logic [NumTaps-1:0]    jtag_tdo_i,
  input  logic [NumIOs-1:0]     out_core_i,
  input  logic [NumIOs-1:0]     oe_core_i,
  output logic [NumIOs-1:0]     in_core_o,
  output logic [NumIOs-1:0]     out_padring_o,
  output logic [NumIOs-1:0]     oe_padring_o,
  input  logic [NumIOs-1:0]     in_padring_i
);

  localparam logic [StrapWidth-1:0] TapNoneW  = StrapWidth'(TapNone);
  localparam logic [StrapWidth-1:0] NumTapsW  = StrapWidth'(NumTaps);
  localparam logic [NumIOs-1:0]     SrstBit   = NumIOs'(1) << SrstIdx;

  logic w_srst_n;

`ifdef JTAG_STRAP_MUX_SRST_EN
  localparam bit SrstEn = 1'b1;

  logic r_srst_sync1;
  logic r_srst_sync2;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_srst_sync1 <= 1'b0;
      r_srst_sync2 <= 1'b0;
    end else begin
      r_srst_sync1 <= in_padring_i[SrstIdx];
      r_srst_sync2 <= r_srst_sync1;
    end
  end

  assign w_srst_n = r_srst_sync2;
`else
  localparam bit SrstEn = 1'b0;

  assign w_srst_n = IdleSrstN;
`endif

  localparam logic [NumIOs-1:0] OvlMask = (NumIOs'(1) << TckIdx) | (NumIOs'(1) << TmsIdx) |
                                          (NumIOs'(1) << TdiIdx) | (NumIOs'(1) << TdoIdx) |
                                          (NumIOs'(1) << TrstIdx) | (SrstEn ? SrstBit : '0);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [StrapWidth-1:0] r_tap_sel;
  logic [StrapWidth-1:0] w_tap_sel_nxt;
  logic                  r_err;
  logic                  w_err_nxt;
  logic [StrapWidth-1:0] w_strap;
  logic                  w_stable;
  logic                  w_locked;
  logic [StrapWidth-1:0] w_tap_sel;
  logic                  w_overlay;

  jtag_strap_debounce #(
    .Width          (StrapWidth),
    .DebounceCycles (DebounceCycles)
  ) u_debounce (
    .i_clk    (clk_i),
    .i_rst_n  (rst_ni),
    .i_en     (r_state == SAMPLE),
    .i_strap  (in_padring_i[StrapIdx +: StrapWidth]),
    .o_value  (w_strap),
    .o_stable (w_stable)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= SAMPLE;
      r_tap_sel <= TapNoneW;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tap_sel <= w_tap_sel_nxt;
      r_err     <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_tap_sel_nxt = r_tap_sel;
    w_err_nxt     = r_err;
    unique case (r_state)
      SAMPLE: begin
        if (w_stable) begin
          w_state_nxt = LOCKED;
          if (w_strap > NumTapsW) begin
            w_tap_sel_nxt = TapNoneW;
            w_err_nxt     = 1'b1;
          end else if (debug_en_i) begin
            w_tap_sel_nxt = w_strap;
          end else begin
            w_tap_sel_nxt = TapNoneW;
          end
        end
      end
      LOCKED: begin
        if (resample_i) begin
          w_state_nxt   = SAMPLE;
          w_tap_sel_nxt = TapNoneW;
        end else if (!debug_en_i) begin
          w_tap_sel_nxt = TapNoneW;
        end
      end
      default: begin
        w_state_nxt   = SAMPLE;
        w_tap_sel_nxt = TapNoneW;
      end
    endcase
  end

  // Losing debug permission must drop the overlay before the register catches up.
  assign w_locked  = (r_state == LOCKED);
  assign w_tap_sel = debug_en_i ? r_tap_sel : TapNoneW;
  assign w_overlay = w_locked && (w_tap_sel != TapNoneW);

  assign tap_sel_o   = w_tap_sel;
  assign locked_o    = w_locked;
  assign strap_err_o = r_err;

  always_comb begin
    in_core_o     = in_padring_i;
    out_padring_o = out_core_i;
    oe_padring_o  = oe_core_i;
    jtag_tck_o    = {NumTaps{IdleTck}};
    jtag_tms_o    = {NumTaps{IdleTms}};
    jtag_tdi_o    = {NumTaps{IdleTdi}};
    jtag_trst_no  = {NumTaps{IdleTrstN}};
    jtag_srst_no  = {NumTaps{IdleSrstN}};
    if (w_overlay) begin
      in_core_o             = (in_padring_i & ~OvlMask) | (TieOffValues & OvlMask);
      out_padring_o         = out_core_i & ~OvlMask;
      oe_padring_o          = oe_core_i & ~OvlMask;
      oe_padring_o[TdoIdx]  = 1'b1;
    end
    for (int t = 0; t < NumTaps; t++) begin
      if (w_overlay && (w_tap_sel == StrapWidth'(t + 1))) begin
        jtag_tck_o[t]         = in_padring_i[TckIdx];
        jtag_tms_o[t]         = in_padring_i[TmsIdx];
        jtag_tdi_o[t]         = in_padring_i[TdiIdx];
        jtag_trst_no[t]       = in_padring_i[TrstIdx];
        jtag_srst_no[t]       = w_srst_n;
        out_padring_o[TdoIdx] = jtag_tdo_i[t];
      end
    end
  end

endmodule

// File: tb/tb_jtag_strap_mux.sv
// Bench for jtag_strap_mux: random pad/core traffic against a cycle-count
// model of strap debounce, lock and overlay routing.
module tb_jtag_strap_mux;

  localparam int NIO  = 47;
  localparam int NT   = 2;
  localparam int SW   = 2;
  localparam int SIDX = 16;
  localparam int TCK  = 43;
  localparam int TMS  = 44;
  localparam int TDI  = 45;
  localparam int TDO  = 46;
  localparam int TRST = 18;
  localparam int SRST = 19;
  localparam logic [NIO-1:0] TIE = '0;

  typedef struct packed {
    logic [NIO-1:0] in_core;
    logic [NIO-1:0] out_pad;
    logic [NIO-1:0] oe_pad;
    logic [NT-1:0]  tck;
    logic [NT-1:0]  tms;
    logic [NT-1:0]  tdi;
    logic [NT-1:0]  trst;
    logic [NT-1:0]  srst;
    logic [SW-1:0]  tap;
    logic           locked;
    logic           err;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic debug_en = 1'b0;
  logic resample = 1'b0;
  logic [SW-1:0]  tap_sel;
  logic           locked;
  logic           err;
  logic [NT-1:0]  tck, tms, trst_n, srst_n, tdi, tdo;
  logic [NIO-1:0] out_core, oe_core, in_core, out_pad, oe_pad, in_pad;

  int n_tests = 0;
  int n_fail = 0;
  int cyc;
  int m_last_chg;
  int m_samp_start;
  logic m_locked, m_err;
  logic [SW-1:0] m_tap;
  logic [SW-1:0] m_strap = '0;
  logic p1, p2;
  logic srst_hold = 1'b0;
  logic srst_val = 1'b1;
  obs_t a_o, e_o;

  always #5 clk = ~clk;

  jtag_strap_mux dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .debug_en_i   (debug_en),
    .resample_i   (resample),
    .tap_sel_o    (tap_sel),
    .locked_o     (locked),
    .strap_err_o  (err),
    .jtag_tck_o   (tck),
    .jtag_tms_o   (tms),
    .jtag_trst_no (trst_n),
    .jtag_srst_no (srst_n),
    .jtag_tdi_o   (tdi),
    .jtag_tdo_i   (tdo),
    .out_core_i   (out_core),
    .oe_core_i    (oe_core),
    .in_core_o    (in_core),
    .out_padring_o(out_pad),
    .oe_padring_o (oe_pad),
    .in_padring_i (in_pad)
  );

  task automatic rand_io();
    in_pad   = NIO'({$urandom(), $urandom()});
    out_core = NIO'({$urandom(), $urandom()});
    oe_core  = NIO'({$urandom(), $urandom()});
    tdo      = NT'($urandom());
    in_pad[SIDX +: SW] = m_strap;
    if (srst_hold) in_pad[SRST] = srst_val;
  endtask

  task automatic set_strap(input logic [SW-1:0] v);
    if (v != m_strap) m_last_chg = cyc;
    m_strap = v;
    in_pad[SIDX +: SW] = v;
  endtask

  // Lock happens 2 sync stages + DebounceCycles after the last strap change,
  // and no sooner than DebounceCycles after sampling (re)starts.
  task automatic model_init();
    cyc = 0;
    m_locked = 1'b0;
    m_tap = '0;
    m_err = 1'b0;
    m_samp_start = 0;
    m_last_chg = (m_strap != 0) ? 0 : -1000;
    p1 = 1'b0;
    p2 = 1'b0;
  endtask

  task automatic tick();
    p2 = p1;
    p1 = in_pad[SRST];
    @(posedge clk);
    cyc++;
    if (m_locked) begin
      if (resample) begin
        m_locked = 1'b0;
        m_tap = '0;
        m_samp_start = cyc;
      end else if (!debug_en) begin
        m_tap = '0;
      end
    end else if (cyc >= m_last_chg + 18 && cyc >= m_samp_start + 16) begin
      m_locked = 1'b1;
      if (m_strap > NT) begin
        m_tap = '0;
        m_err = 1'b1;
      end else begin
        m_tap = debug_en ? m_strap : '0;
      end
    end
    #1;
    resample = 1'b0;
    rand_io();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_init();
  endtask

  function automatic obs_t actual_obs();
    obs_t a;
    a.in_core = in_core; a.out_pad = out_pad; a.oe_pad = oe_pad;
    a.tck = tck; a.tms = tms; a.tdi = tdi; a.trst = trst_n; a.srst = srst_n;
    a.tap = tap_sel; a.locked = locked; a.err = err;
    return a;
  endfunction

  function automatic obs_t expect_obs();
    obs_t e;
    int ovl[$];
    logic [SW-1:0] sel;
    sel = (m_locked && debug_en) ? m_tap : '0;
    e.tap = sel; e.locked = m_locked; e.err = m_err;
    e.in_core = in_pad; e.out_pad = out_core; e.oe_pad = oe_core;
    e.tck = '0; e.tms = '1; e.tdi = '0; e.trst = '0; e.srst = '1;
    ovl = '{TCK, TMS, TDI, TDO, TRST};
`ifdef JTAG_STRAP_MUX_SRST_EN
    ovl.push_back(SRST);
`endif
    if (m_locked && sel != 0) begin
      foreach (ovl[i]) begin
        e.in_core[ovl[i]] = TIE[ovl[i]];
        e.out_pad[ovl[i]] = 1'b0;
        e.oe_pad[ovl[i]]  = 1'b0;
      end
      e.oe_pad[TDO] = 1'b1;
      for (int t = 0; t < NT; t++) begin
        if (int'(sel) == t + 1) begin
          e.out_pad[TDO] = tdo[t];
          e.tck[t]  = in_pad[TCK];
          e.tms[t]  = in_pad[TMS];
          e.tdi[t]  = in_pad[TDI];
          e.trst[t] = in_pad[TRST];
`ifdef JTAG_STRAP_MUX_SRST_EN
          e.srst[t] = p2;
`endif
        end
      end
    end
    return e;
  endfunction

  task automatic test_reset();
    debug_en = 1'b1;
    set_strap(2'b11);
    do_reset();
    repeat (20) tick();
    rst_n = 1'b0;
    #1;
    model_init();
    a_o = actual_obs(); e_o = expect_obs(); n_tests++;
    if (a_o !== e_o) begin n_fail++; $display("FAIL reset_async got=%h exp=%h", a_o, e_o); end
    n_tests++;
    if (locked !== 1'b0 || tap_sel !== 2'd0 || err !== 1'b0) begin
      n_fail++; $display("FAIL reset_regs got locked=%b tap=%0d err=%b exp 0/0/0", locked, tap_sel, err);
    end
    repeat (2) @(posedge clk);
    #1;
    a_o = actual_obs(); e_o = expect_obs(); n_tests++;
    if (a_o !== e_o) begin n_fail++; $display("FAIL reset_hold got=%h exp=%h", a_o, e_o); end
  endtask

  task automatic test_lock_basic();
    debug_en = 1'b1;
    set_strap(2'b01);
    do_reset();
    for (int i = 0; i < 22; i++) begin
      tick();
      a_o = actual_obs(); e_o = expect_obs(); n_tests++;
      if (a_o !== e_o) begin n_fail++; $display("FAIL lock_basic cyc=%0d got=%h exp=%h", cyc, a_o, e_o); end
      if (cyc == 17 || cyc == 18) begin
        n_tests++;
        if (locked !== (cyc == 18)) begin
          n_fail++; $display("FAIL lock_basic_time cyc=%0d got locked=%b exp %b", cyc, locked, cyc == 18);
        end
      end
    end
    n_tests++;
    if (tap_sel !== 2'd1 || oe_pad[TDO] !== 1'b1 || out_pad[TDO] !== tdo[0] || in_core[TCK] !== TIE[TCK]) begin
      n_fail++;
      $display("FAIL lock_basic_route got tap=%0d oe=%b tdo=%b tck_core=%b exp tap=1 oe=1 tdo=%b tck_core=%b",
               tap_sel, oe_pad[TDO], out_pad[TDO], in_core[TCK], tdo[0], TIE[TCK]);
    end
  endtask

  task automatic test_debounce_toggle();
    int last;
    int lock_at;
    debug_en = 1'b1;
    set_strap(2'b01);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_strap((i % 2 == 0) ? 2'b10 : 2'b01);
      for (int j = 0; j < 10; j++) begin
        tick();
        a_o = actual_obs(); e_o = expect_obs(); n_tests++;
        if (a_o !== e_o || locked !== 1'b0) begin
          n_fail++; $display("FAIL toggle_nolock cyc=%0d got=%h exp=%h", cyc, a_o, e_o);
        end
      end
    end
    set_strap(2'b10);
    last = cyc;
    lock_at = -1;
    for (int i = 0; i < 40 && lock_at < 0; i++) begin
      tick();
      a_o = actual_obs(); e_o = expect_obs(); n_tests++;
      if (a_o !== e_o) begin n_fail++; $display("FAIL toggle_settle cyc=%0d got=%h exp=%h", cyc, a_o, e_o); end
      if (locked === 1'b1) lock_at = cyc;
    end
    n_tests++;
    if (lock_at != last + 18 || tap_sel !== 2'd2) begin
      n_fail++; $display("FAIL toggle_lock got at=%0d tap=%0d exp at=%0d tap=2", lock_at, tap_sel, last + 18);
    end
  endtask

  task automatic test_strap_err();
    debug_en = 1'b1;
    set_strap(2'b11);
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      a_o = actual_obs(); e_o = expect_obs(); n_tests++;
      if (a_o !== e_o) begin n_fail++; $display("FAIL strap_err cyc=%0d got=%h exp=%h", cyc, a_o, e_o); end
    end
    n_tests++;
    if (locked !== 1'b1 || tap_sel !== 2'd0 || err !== 1'b1 || in_core !== in_pad ||
        out_pad !== out_core || oe_pad !== oe_core) begin
      n_fail++; $display("FAIL strap_err_pass got locked=%b tap=%0d err=%b exp 1/0/1 passthrough", locked, tap_sel, err);
    end
    set_strap(2'b01);
    resample = 1'b1;
    for (int i = 0; i < 22; i++) begin
      tick();
      a_o = actual_obs(); e_o = expect_obs(); n_tests++;
      if (a_o !== e_o) begin n_fail++; $display("FAIL strap_err_relock cyc=%0d got=%h exp=%h", cyc, a_o, e_o); end
    end
    n_tests++;
    if (err !== 1'b1 || tap_sel !== 2'd1) begin
      n_fail++; $display("FAIL strap_err_sticky got err=%b tap=%0d exp err=1 tap=1", err, tap_sel);
    end
  endtask

  task automatic test_debug_drop();
    debug_en = 1'b1;
    set_strap(2'b01);
    do_reset();
    repeat (20) tick();
    debug_en = 1'b0;
    #1;
    a_o = actual_obs(); e_o = expect_obs(); n_tests++;
    if (a_o !== e_o) begin n_fail++; $display("FAIL dbg_drop_comb got=%h exp=%h", a_o, e_o); end
    n_tests++;
    if (tap_sel !== 2'd0 || trst_n[0] !== 1'b0 || in_core !== in_pad || locked !== 1'b1) begin
      n_fail++; $display("FAIL dbg_drop_now got tap=%0d trst0=%b locked=%b exp tap=0 trst0=0 locked=1", tap_sel, trst_n[0], locked);
    end
    tick();
    debug_en = 1'b1;
    #1;
    a_o = actual_obs(); e_o = expect_obs(); n_tests++;
    if (a_o !== e_o || tap_sel !== 2'd0) begin
      n_fail++; $display("FAIL dbg_drop_cleared got=%h exp=%h", a_o, e_o);
    end
  endtask

  task automatic test_resample();
    int e_edge;
    int lock_at;
    debug_en = 1'b1;
    set_strap(2'b01);
    do_reset();
    repeat (20) tick();
    set_strap(2'b10);
    resample = 1'b1;
    e_edge = cyc;
    tick();
    n_tests++;
    if (locked !== 1'b0 || trst_n !== 2'b00 || tck !== 2'b00 || tms !== 2'b11 || tdi !== 2'b00) begin
      n_fail++; $display("FAIL resample_drop got locked=%b trst=%b tck=%b tms=%b tdi=%b exp 0/00/00/11/00",
                         locked, trst_n, tck, tms, tdi);
    end
    lock_at = -1;
    for (int i = 0; i < 30 && lock_at < 0; i++) begin
      tick();
      a_o = actual_obs(); e_o = expect_obs(); n_tests++;
      if (a_o !== e_o) begin n_fail++; $display("FAIL resample_wait cyc=%0d got=%h exp=%h", cyc, a_o, e_o); end
      if (locked === 1'b1) lock_at = cyc;
    end
    n_tests++;
    if (lock_at != e_edge + 18 || tap_sel !== 2'd2 || tck[0] !== 1'b0 || tms[0] !== 1'b1 ||
        tdi[0] !== 1'b0 || trst_n[0] !== 1'b0) begin
      n_fail++; $display("FAIL resample_relock got at=%0d tap=%0d tap1 tck=%b tms=%b tdi=%b trst=%b exp at=%0d tap=2 0/1/0/0",
                         lock_at, tap_sel, tck[0], tms[0], tdi[0], trst_n[0], e_edge + 18);
    end
  endtask

  task automatic test_srst();
    logic exp_srst;
`ifdef JTAG_STRAP_MUX_SRST_EN
    exp_srst = 1'b0;
`else
    exp_srst = 1'b1;
`endif
    debug_en = 1'b1;
    set_strap(2'b01);
    srst_hold = 1'b1;
    srst_val = 1'b1;
    rand_io();
    do_reset();
    repeat (20) tick();
    srst_val = 1'b0;
    in_pad[SRST] = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      tick();
      a_o = actual_obs(); e_o = expect_obs(); n_tests++;
      if (a_o !== e_o) begin n_fail++; $display("FAIL srst_route cyc=%0d got=%h exp=%h", cyc, a_o, e_o); end
    end
    n_tests++;
    if (srst_n[0] !== exp_srst || srst_n[1] !== 1'b1) begin
      n_fail++; $display("FAIL srst_level got srst=%b exp %b%b", srst_n, 1'b1, exp_srst);
    end
    srst_hold = 1'b0;
  endtask

  task automatic test_random();
    debug_en = 1'b1;
    set_strap(SW'($urandom_range(1, 3)));
    do_reset();
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 39) == 0) set_strap(SW'($urandom_range(0, 3)));
      if ($urandom_range(0, 59) == 0) debug_en = ~debug_en;
      if ($urandom_range(0, 29) == 0) resample = 1'b1;
      #1;
      a_o = actual_obs(); e_o = expect_obs(); n_tests++;
      if (a_o !== e_o) begin n_fail++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, a_o, e_o); end
      tick();
    end
  endtask

  initial begin
    model_init();
    rand_io();
    test_reset();
    test_lock_basic();
    test_debounce_toggle();
    test_strap_err();
    test_debug_drop();
    test_resample();
    test_srst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
